maze_move_arbiter: RTL and testbench
====================================

// Module: maze_move_arbiter
// PURPOSE
// - Registered, multi-agent successor to the combinational wall checker.
// - Holds the maze wall map in flops and reloads it row-by-row from preset maps (start screen / level).
// - Accepts runtime door edits to single horizontal wall bits.
// - Serves move-legality queries from N_AGENTS agents (Pac-Man plus ghosts) through a round-robin req/ack arbiter.
// - Sits between the agent movement FSMs and the maze/level controller.
// PARAMETERS
// - COLS      12  playable cells per row; X = 1..COLS; X = 0 and X = COLS+1 are tunnel cells
// - ROWS      12  playable rows; Y = 1..ROWS; Y = 0 is the spawn lane above the maze
// - N_AGENTS   4  number of query channels; agent 0 = Pac-Man
// - CW         5  coordinate width; must satisfy 2**CW > COLS+1 and 2**CW > ROWS
// PORTS
// - Clk          in   1              system clock
// - Reset_n      in   1              asynchronous, active-low reset
// - load         in   1              one-cycle pulse: start a wall-map reload
// - load_sel     in   1              0 = START preset, 1 = LEVEL preset; sampled with load
// - busy         out  1              high while a reload is in progress
// - door_we      in   1              write one horizontal wall bit
// - door_idx     in   $clog2((ROWS+1)*COLS)  horizontal wall bit index
// - door_val     in   1              1 = wall, 0 = open
// - req          in   N_AGENTS       per-agent query request; held high until ack
// - qx, qy       in   N_AGENTS*CW    per-agent cell coordinates, packed, agent i at [i*CW +: CW]
// - ack          out  N_AGENTS       one-hot pulse; result for that agent is on rsp_* this cycle
// - rsp_valid    out  1              response valid
// - rsp_id       out  $clog2(N_AGENTS)  agent served
// - rsp_ok       out  4              legal moves {up, down, left, right}; 1 = open
// BEHAVIOUR
// - Storage:
//   - vert: ROWS*(COLS+1) bits; horiz: (ROWS+1)*COLS bits; 1 = wall.
//   - For cell (c, r):
//     - left  = vert[(r-1)*(COLS+1)+c-1]
//     - right = vert[(r-1)*(COLS+1)+c]
//     - up    = horiz[(r-1)*COLS+c-1]
//     - down  = horiz[r*COLS+c-1]
//   - rsp_ok = inverted wall bits.
// - Boundary cells (rule checked first wins):
//   - qy > ROWS            -> 4'b1000
//   - qy = 0               -> 4'b0100
//   - qx = 0               -> 4'b0001
//   - qx > COLS, qy in range -> 4'b0010
// - FSM states: LOAD, SERVE.
//   - Reset -> LOAD with START preset; row counter = 0.
//   - LOAD: one step per cycle, ROWS+1 cycles total. Step k writes horiz row k and, if k < ROWS, vert row k.
//   - LOAD -> SERVE after step ROWS.
//   - busy = 1 in LOAD.
//   - load in SERVE restarts LOAD at k = 0.
//   - load in LOAD restarts LOAD at k = 0 with the new load_sel.
// - Arbiter:
//   - In SERVE, each cycle grant the lowest requesting index at or after ptr.
//   - Latch its coordinates; ptr <= grant+1 (mod N_AGENTS).
//   - No grants in LOAD. Requests stay pending; they are not dropped.
// - Latency:
//   - Grant in cycle t -> rsp_valid, rsp_id, rsp_ok, ack[id] in cycle t+1.
//   - Sustained throughput is one response per cycle.
//   - The agent drops or changes req in t+2 or later. A req still high in t+1 is not re-granted in t+1.
// - Door writes:
//   - Accepted only in SERVE; ignored in LOAD.
//   - A query granted in the same cycle as a write sees the old value; later grants see the new value.
//   - door_idx out of range: ignored.
// - Reset values:
//   - busy = 1; ack = 0; rsp_valid = 0; rsp_id = 0; rsp_ok = 0; ptr = 0.
//   - vert and horiz = all 1s (all walls).
// - Reset mid-LOAD: aborts; LOAD restarts with the START preset.
// STRUCTURE
// - maze_pkg holds:
//   - typedef dir_t {UP, DOWN, LEFT, RIGHT}
//   - typedef state_t {LOAD, SERVE}
//   - START_VERT, START_HORIZ, LEVEL_VERT, LEVEL_HORIZ preset constants for the 12x12 default map
// - One sub-module: maze_cell_lookup, combinational: (vert, horiz, x, y) -> rsp_ok, including the boundary rules.
// TESTING
// - Reset release: busy = 1 for exactly 13 cycles, then 0. Any req during LOAD gets no ack before busy falls.
// - After load_sel = 1 reload: agent 0 queries (1,1) -> rsp_ok = ~{h[0], h[12], v[0], v[1]} of LEVEL preset, 1 cycle after grant.
// - Boundary queries:
//   - (0,5)  -> 4'b0001
//   - (5,0)  -> 4'b0100
//   - (13,5) -> 4'b0010
//   - (3,14) -> 4'b1000
// - req = 4'b1111 held, ptr = 0: ack sequence 0001, 0010, 0100, 1000 on consecutive cycles. With req = 4'b1010: ids alternate 1, 3.
// - door_we idx 24 val 0 with simultaneous grant of (1,2): response shows down = 0 (wall). The next query of (1,2) shows down = 1.
// - Reset_n pulsed at LOAD step 6: outputs return to reset values. busy stays high for a full 13-cycle START load.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and preset wall maps for the maze move arbiter
package maze_pkg;

    localparam int P_COLS  = 12;
    localparam int P_ROWS  = 12;
    localparam int VERT_W  = P_ROWS * (P_COLS + 1);
    localparam int HORIZ_W = (P_ROWS + 1) * P_COLS;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic {LOAD, SERVE} state_t;

    // Start screen: only the outer frame is walled.
    localparam logic [VERT_W-1:0]  START_VERT  = {P_ROWS{13'b1_0000_0000_0001}};
    localparam logic [HORIZ_W-1:0] START_HORIZ = {12'hFFF, {(P_ROWS-1){12'h000}}, 12'hFFF};

    // Level map: vertical walls every third column, repeating horizontal pattern.
    localparam logic [VERT_W-1:0]  LEVEL_VERT  = {P_ROWS{13'b1_0010_0100_1001}};
    localparam logic [HORIZ_W-1:0] LEVEL_HORIZ = {12'hFFF, {(P_ROWS-1){12'h0A5}}, 12'hFFF};

    // Bit position of a direction inside the {up, down, left, right} response.
    function automatic logic [1:0] dir_bit(input dir_t d);
        return 2'(3 - int'(d));
    endfunction

endpackage

// File: rtl/maze_cell_lookup.sv
// rtl/maze_cell_lookup.sv - combinational wall lookup for one cell, boundary cells included
module maze_cell_lookup
    import maze_pkg::*;
#(
    parameter int COLS = 12,
    parameter int ROWS = 12,
    parameter int CW   = 5
) (
    input  logic [ROWS*(COLS+1)-1:0] i_vert,
    input  logic [(ROWS+1)*COLS-1:0] i_horiz,
    input  logic [CW-1:0]            i_x,
    input  logic [CW-1:0]            i_y,
    output logic [3:0]               o_ok
);

    localparam int VW  = ROWS * (COLS + 1);
    localparam int HW  = (ROWS + 1) * COLS;
    localparam int VIW = $clog2(VW);
    localparam int HIW = $clog2(HW);

    logic [VIW-1:0] w_il;
    logic [VIW-1:0] w_ir;
    logic [HIW-1:0] w_iu;
    logic [HIW-1:0] w_id;

    always_comb begin
        w_il = VIW'((int'(i_y) - 1) * (COLS + 1) + int'(i_x) - 1);
        w_ir = VIW'((int'(i_y) - 1) * (COLS + 1) + int'(i_x));
        w_iu = HIW'((int'(i_y) - 1) * COLS + int'(i_x) - 1);
        w_id = HIW'(int'(i_y) * COLS + int'(i_x) - 1);
    end

    // Tunnel and spawn-lane cells only ever allow the single move back into the maze.
    always_comb begin
        o_ok = '0;
        if (i_y > CW'(ROWS)) begin
            o_ok = 4'b1000;
        end else if (i_y == '0) begin
            o_ok = 4'b0100;
        end else if (i_x == '0) begin
            o_ok = 4'b0001;
        end else if (i_x > CW'(COLS)) begin
            o_ok = 4'b0010;
        end else begin
            o_ok[dir_bit(UP)]    = ~i_horiz[w_iu];
            o_ok[dir_bit(DOWN)]  = ~i_horiz[w_id];
            o_ok[dir_bit(LEFT)]  = ~i_vert[w_il];
            o_ok[dir_bit(RIGHT)] = ~i_vert[w_ir];
        end
    end

endmodule

// File: rtl/maze_move_arbiter.sv
// rtl/maze_move_arbiter.sv - registered wall map with row-wise reload, door edits and
// round-robin move-legality queries for several agents
module maze_move_arbiter
    import maze_pkg::*;
#(
    parameter int COLS     = 12,
    parameter int ROWS     = 12,
    parameter int N_AGENTS = 4,
    parameter int CW       = 5
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic                                load,
    input  logic                                load_sel,
    output logic                                busy,
    input  logic                                door_we,
    input  logic [$clog2((ROWS+1)*COLS)-1:0]    door_idx,
    input  logic                                door_val,
    input  logic [N_AGENTS-1:0]                 req,
    input  logic [N_AGENTS*CW-1:0]              qx,
    input  logic [N_AGENTS*CW-1:0]              qy,
    output logic [N_AGENTS-1:0]                 ack,
    output logic                                rsp_valid,
    output logic [$clog2(N_AGENTS)-1:0]         rsp_id,
    output logic [3:0]                          rsp_ok
);

    localparam int VW  = ROWS * (COLS + 1);
    localparam int HW  = (ROWS + 1) * COLS;
    localparam int RW  = $clog2(ROWS + 1);
    localparam int IDW = $clog2(N_AGENTS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RW-1:0]      r_row;
    logic [RW-1:0]      w_row_nxt;
    logic               r_sel;
    logic               w_sel_nxt;
    logic [VW-1:0]      r_vert;
    logic [HW-1:0]      r_horiz;
    logic [VW-1:0]      w_pre_vert;
    logic [HW-1:0]      w_pre_horiz;

    logic [IDW-1:0]      r_ptr;
    logic [N_AGENTS-1:0] r_ack;
    logic                r_rsp_valid;
    logic [IDW-1:0]      r_rsp_id;
    logic [3:0]          r_rsp_ok;

    logic [N_AGENTS-1:0] w_req_eff;
    logic [IDW-1:0]      w_cand;
    logic                w_gnt_vld;
    logic [IDW-1:0]      w_gnt_id;
    logic [IDW-1:0]      w_ptr_nxt;
    logic [CW-1:0]       w_gx;
    logic [CW-1:0]       w_gy;
    logic [3:0]          w_ok;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= LOAD;
            r_row   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_sel_nxt   = r_sel;
        case (r_state)
            LOAD: begin
                if (load) begin
                    w_row_nxt = '0;
                    w_sel_nxt = load_sel;
                end else if (r_row == RW'(ROWS)) begin
                    w_state_nxt = SERVE;
                    w_row_nxt   = '0;
                end else begin
                    w_row_nxt = r_row + 1'b1;
                end
            end
            SERVE: begin
                if (load) begin
                    w_state_nxt = LOAD;
                    w_row_nxt   = '0;
                    w_sel_nxt   = load_sel;
                end
            end
            default: begin
                w_state_nxt = LOAD;
                w_row_nxt   = '0;
            end
        endcase
    end

    assign busy        = (r_state == LOAD);
    assign w_pre_vert  = r_sel ? LEVEL_VERT  : START_VERT;
    assign w_pre_horiz = r_sel ? LEVEL_HORIZ : START_HORIZ;

    // Row k of the preset is copied at step k; the last step has only a horizontal row.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vert  <= '1;
            r_horiz <= '1;
        end else if (r_state == LOAD) begin
            for (int k = 0; k <= ROWS; k++) begin
                if (r_row == RW'(k)) begin
                    r_horiz[k*COLS +: COLS] <= w_pre_horiz[k*COLS +: COLS];
                end
            end
            for (int k = 0; k < ROWS; k++) begin
                if (r_row == RW'(k)) begin
                    r_vert[k*(COLS+1) +: COLS+1] <= w_pre_vert[k*(COLS+1) +: COLS+1];
                end
            end
        end else if (door_we && (int'(door_idx) < HW)) begin
            r_horiz[door_idx] <= door_val;
        end
    end

    // An agent acked this cycle is masked so its still-high req is not served twice.
    always_comb begin
        w_req_eff = req & ~r_ack;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_cand    = '0;
        if ((r_state == SERVE) && !load) begin
            for (int off = N_AGENTS - 1; off >= 0; off--) begin
                w_cand = IDW'((int'(r_ptr) + off) % N_AGENTS);
                if (w_req_eff[w_cand]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = w_cand;
                end
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_id == IDW'(N_AGENTS - 1)) ? '0 : w_gnt_id + 1'b1;

    always_comb begin
        w_gx = '0;
        w_gy = '0;
        for (int i = 0; i < N_AGENTS; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_gx = qx[i*CW +: CW];
                w_gy = qy[i*CW +: CW];
            end
        end
    end

    maze_cell_lookup #(
        .COLS (COLS),
        .ROWS (ROWS),
        .CW   (CW)
    ) u_lookup (
        .i_vert  (r_vert),
        .i_horiz (r_horiz),
        .i_x     (w_gx),
        .i_y     (w_gy),
        .o_ok    (w_ok)
    );

    // The result is captured at grant time, so a door edit in the same cycle is not visible.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr       <= '0;
            r_ack       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_ok    <= '0;
        end else begin
            r_rsp_valid <= w_gnt_vld;
            r_ack       <= '0;
            if (w_gnt_vld) begin
                r_ack[w_gnt_id] <= 1'b1;
                r_rsp_id        <= w_gnt_id;
                r_rsp_ok        <= w_ok;
                r_ptr           <= w_ptr_nxt;
            end
        end
    end

    assign ack       = r_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_ok    = r_rsp_ok;

endmodule

// File: tb/tb_maze_move_arbiter.sv
// tb/tb_maze_move_arbiter.sv - scoreboard bench for maze_move_arbiter
module tb_maze_move_arbiter;

    localparam int COLS = 12;
    localparam int ROWS = 12;
    localparam int NA   = 4;
    localparam int CW   = 5;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              load;
    logic              load_sel;
    logic              busy;
    logic              door_we;
    logic [7:0]        door_idx;
    logic              door_val;
    logic [NA-1:0]     req;
    logic [NA*CW-1:0]  qx;
    logic [NA*CW-1:0]  qy;
    logic [NA-1:0]     ack;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [3:0]        rsp_ok;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] ok;
    } exp_t;

    exp_t         sb[$];
    logic [CW-1:0] px [NA][16];
    logic [CW-1:0] py [NA][16];
    int           ph [NA];
    int           pt [NA];

    always #5 Clk = ~Clk;

    maze_move_arbiter #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .N_AGENTS (NA),
        .CW       (CW)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .load      (load),
        .load_sel  (load_sel),
        .busy      (busy),
        .door_we   (door_we),
        .door_idx  (door_idx),
        .door_val  (door_val),
        .req       (req),
        .qx        (qx),
        .qy        (qy),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_ok    (rsp_ok)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input int a, input int x, input int y, input logic [3:0] ok);
        exp_t e;
        px[a][pt[a]] = CW'(x);
        py[a][pt[a]] = CW'(y);
        pt[a]++;
        e.id = 2'(a);
        e.ok = ok;
        sb.push_back(e);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            @(negedge Clk);
        end
        check(name, 32'(n), 32'd13);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && req == '0) break;
            @(negedge Clk);
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd1);
        check({tag, "_ack"},       32'(ack),       32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_ok"},    32'(rsp_ok),    32'd0);
    endtask

    // Agent model: holds req with its coordinates until acked, then moves to its next query.
    always @(negedge Clk) begin
        for (int i = 0; i < NA; i++) begin
            if (req[i] && ack[i]) req[i] = 1'b0;
            if (!req[i] && ph[i] != pt[i]) begin
                qx[i*CW +: CW] = px[i][ph[i]];
                qy[i*CW +: CW] = py[i][ph[i]];
                ph[i]++;
                req[i] = 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n && busy) begin
            check("no_rsp_in_load", 32'(rsp_valid), 32'd0);
        end
        if (rsp_valid) begin
            check("ack_onehot", 32'(ack), 32'd1 << rsp_id);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d ok %b expected none", rsp_id, rsp_ok);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_ok", 32'(rsp_ok), 32'(e.ok));
            end
        end else begin
            check("ack_idle", 32'(ack), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n  = 1'b0;
        load     = 1'b0;
        load_sel = 1'b0;
        door_we  = 1'b0;
        door_idx = '0;
        door_val = 1'b0;
        req      = '0;
        qx       = '0;
        qy       = '0;
        repeat (2) @(negedge Clk);
        check_reset_outputs("reset");

        // Requests raised during the reset load; served 0,1,2,3 once busy falls.
        @(posedge Clk); #1;
        issue(0, 0, 5, 4'b0001);
        issue(1, 5, 0, 4'b0100);
        issue(2, 13, 5, 4'b0010);
        issue(3, 3, 14, 4'b1000);
        @(negedge Clk);
        Reset_n = 1'b1;
        count_busy("busy_after_reset");
        drain("drain_boundary");

        // LEVEL reload; a door write held through LOAD must be ignored.
        @(negedge Clk);
        load     = 1'b1;
        load_sel = 1'b1;
        @(negedge Clk);
        load     = 1'b0;
        door_we  = 1'b1;
        door_idx = 8'd12;
        door_val = 1'b0;
        count_busy("busy_level_load");
        door_we  = 1'b0;
        @(posedge Clk); #1;
        issue(0, 1, 1, 4'b0001);
        drain("drain_level_11");

        // ptr = 1 here: agents 1 and 3 alternate.
        @(posedge Clk); #1;
        issue(1, 2, 3, 4'b1111);
        issue(3, 12, 6, 4'b1110);
        issue(1, 3, 3, 4'b0010);
        issue(3, 1, 12, 4'b0001);
        issue(1, 13, 13, 4'b1000);
        issue(3, 0, 0, 4'b0100);
        drain("drain_alternate");

        // Door opened in the same cycle as the grant: old value first, new value next.
        @(posedge Clk); #1;
        issue(2, 1, 2, 4'b0001);
        issue(2, 1, 2, 4'b0101);
        @(negedge Clk);
        door_we  = 1'b1;
        door_idx = 8'd24;
        door_val = 1'b0;
        @(negedge Clk);
        door_we  = 1'b0;
        drain("drain_door");

        // Reset during LOAD step 6 of a LEVEL reload.
        @(negedge Clk);
        load     = 1'b1;
        load_sel = 1'b1;
        @(negedge Clk);
        load     = 1'b0;
        repeat (6) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_load_reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        count_busy("busy_after_mid_reset");
        @(posedge Clk); #1;
        issue(1, 1, 1, 4'b0101);
        drain("drain_start_11");
        @(posedge Clk); #1;
        issue(2, 1, 2, 4'b1101);
        drain("drain_start_12");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
